// File: rtl/sap_control_unit.sv
// SAP 16-bit fetch/decode/execute sequencer: PC, IR, ACC, B, flags.
// Optional SAP_SINGLE_STEP_EN adds a step input gating each instruction fetch.
module sap_control_unit #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SAP_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_op,
  input  logic [15:0]       alu_out,
  input  logic [1:0]        alu_flag,
  output logic [15:0]       out_data,
  output logic              out_valid,
  output logic              halted
);

  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_STA, OP_ADD,
    OP_SUB, OP_INC, OP_DEC, OP_AND,
    OP_OR,  OP_XOR, OP_NOT, OP_JMP,
    OP_JZ,  OP_JV,  OP_OUT, OP_HLT
  } opcode_t;

`ifdef SAP_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM,
    S_EXEC, S_STORE, S_HALT, S_STEP
  } state_t;
  localparam state_t S_ENTRY = S_STEP;
`else
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM,
    S_EXEC, S_STORE, S_HALT
  } state_t;
  localparam state_t S_ENTRY = S_FETCH;
`endif

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [15:0]       ir, ir_n;
  logic [15:0]       acc, acc_n;
  logic [15:0]       b, b_n;
  logic [1:0]        flags, flags_n;
  logic [15:0]       outd_n;
  logic              outv_n;

  opcode_t           op;
  logic [ADDR_W-1:0] opd;
  logic              grp_exec, grp_mem;

  assign op  = opcode_t'(ir[15:12]);
  assign opd = ir[ADDR_W-1:0];

  assign grp_exec = (op == OP_INC) || (op == OP_DEC) ||
                    (op == OP_NOT);
  assign grp_mem  = (op == OP_LDA) || (op == OP_ADD) ||
                    (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_XOR);

`ifdef SAP_SINGLE_STEP_EN
  // A step pulse seen mid-instruction is remembered for the next fetch.
  logic pend, pend_n;
  logic go;
  assign go = step | pend;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    acc_n   = acc;
    b_n     = b;
    flags_n = flags;
    outd_n  = out_data;
    outv_n  = 1'b0;
`ifdef SAP_SINGLE_STEP_EN
    pend_n  = pend | step;
`endif
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_n    = mem_rdata;
          pc_n    = pc + ADDR_W'(1);
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = S_ENTRY;
        unique case (1'b1)
          op == OP_NOP: state_n = S_ENTRY;
          op == OP_HLT: state_n = S_HALT;
          op == OP_JMP: pc_n = opd;
          op == OP_JZ:  if (flags[0]) pc_n = opd;
          op == OP_JV:  if (flags[1]) pc_n = opd;
          op == OP_OUT: begin
            outd_n = acc;
            outv_n = 1'b1;
          end
          grp_exec:     state_n = S_EXEC;
          grp_mem:      state_n = S_MEM;
          op == OP_STA: state_n = S_STORE;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_LDA) begin
            acc_n   = mem_rdata;
            state_n = S_ENTRY;
          end else begin
            b_n     = mem_rdata;
            state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        acc_n   = alu_out;
        flags_n = alu_flag;
        state_n = S_ENTRY;
      end
      S_STORE: begin
        if (mem_ready) state_n = S_ENTRY;
      end
      S_HALT: state_n = S_HALT;
`ifdef SAP_SINGLE_STEP_EN
      S_STEP: begin
        if (go) begin
          state_n = S_FETCH;
          pend_n  = 1'b0;
        end
      end
`endif
      default: state_n = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ENTRY;
      pc        <= PC0;
      ir        <= '0;
      acc       <= '0;
      b         <= '0;
      flags     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      acc       <= acc_n;
      b         <= b_n;
      flags     <= flags_n;
      out_data  <= outd_n;
      out_valid <= outv_n;
    end
  end

`ifdef SAP_SINGLE_STEP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= pend_n;
  end
`endif

  // Requests are masked while reset is held so the bus is idle in reset.
  assign mem_rd = rst_n &&
                  ((state == S_FETCH) || (state == S_MEM));
  assign mem_wr = rst_n && (state == S_STORE);
  assign mem_addr  = (state == S_FETCH) ? pc : opd;
  assign mem_wdata = acc;

  assign alu_a  = acc;
  assign alu_b  = b;
  assign alu_op = (ir[15:12] >= 4'd3 && ir[15:12] <= 4'd10) ?
                  ir[15:12] - 4'd3 : 4'd0;

  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_sap_control_unit.sv
// Bench for sap_control_unit: memory/ALU models, scoreboard of bus
// transactions and output pulses checked by an independent monitor.
module tb_sap_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic [1:0]  alu_flag;
  logic [15:0] out_data;
  logic        out_valid, halted;

  sap_control_unit #(.ADDR_W(12), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .out_data(out_data), .out_valid(out_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  int          cnt = 0;
  int          wait_n;
  logic        slow;

  assign mem_rdata = mem[mem_addr];

  always_comb begin
    wait_n = 0;
    if (mem_wr) wait_n = 3;
    else if (slow && mem_addr == 12'h007) wait_n = 60;
    else if (mem_rd && mem_addr == 12'h009) wait_n = 2;
  end

  assign mem_ready = (mem_rd || mem_wr) && (cnt >= wait_n);

  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end

  logic [16:0] t;
  always_comb begin
    t = '0;
    case (alu_op)
      4'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2: t = {1'b0, alu_a} + 17'd1;
      4'd3: t = {1'b0, alu_a} - 17'd1;
      4'd4: t = {1'b0, alu_a & alu_b};
      4'd5: t = {1'b0, alu_a | alu_b};
      4'd6: t = {1'b0, alu_a ^ alu_b};
      4'd7: t = {1'b0, ~alu_a};
      default: t = '0;
    endcase
  end
  assign alu_out  = t[15:0];
  assign alu_flag = {t[16], t[15:0] == 16'h0};

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        q[$];
  logic [15:0] oq[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cycles = 0;
  int          outs = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic ex(input logic wr, input logic [11:0] a,
                    input logic [15:0] d);
    txn_t e;
    e.wr = wr; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (mem_rd || mem_wr)
        chk("rd_wr_excl", {31'd0, mem_rd && mem_wr}, 0);
      if (mem_wr) begin
        wr_cycles++;
        if (q.size() > 0 && q[0].wr) begin
          chk("wr_addr_hold", {20'd0, mem_addr}, {20'd0, q[0].addr});
          chk("wr_data_hold", {16'd0, mem_wdata}, {16'd0, q[0].data});
        end
      end
      if ((mem_rd || mem_wr) && mem_ready) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL txn_unexpected addr=%h wr=%b", mem_addr, mem_wr);
        end else begin
          txn_t e;
          e = q.pop_front();
          chk("txn_kind", {31'd0, mem_wr}, {31'd0, e.wr});
          chk("txn_addr", {20'd0, mem_addr}, {20'd0, e.addr});
          chk("txn_acc", {16'd0, mem_wr ? mem_wdata : alu_a},
              {16'd0, e.data});
        end
      end
      if (out_valid) begin
        outs++;
        if (oq.size() == 0) begin
          errors++; checks++;
          $display("FAIL out_unexpected act=%h", out_data);
        end else begin
          chk("out_data", {16'd0, out_data}, {16'd0, oq.pop_front()});
        end
      end
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
  endtask

  initial begin
    int rd_seen;
    int k;
    rst_n = 1'b0;
    slow  = 1'b0;
    clr_mem();
    mem[12'h000] = 16'h1005; mem[12'h001] = 16'h1006;
    mem[12'h002] = 16'h3006; mem[12'h003] = 16'hD020;
    mem[12'h020] = 16'h1007; mem[12'h021] = 16'h6000;
    mem[12'h022] = 16'hC040;
    mem[12'h040] = 16'h1009; mem[12'h041] = 16'hC045;
    mem[12'h045] = 16'h5000; mem[12'h046] = 16'h2010;
    mem[12'h047] = 16'h1008; mem[12'h048] = 16'hC0F0;
    mem[12'h049] = 16'h4009; mem[12'h04A] = 16'h7009;
    mem[12'h04B] = 16'h8009; mem[12'h04C] = 16'h9009;
    mem[12'h04D] = 16'hA000; mem[12'h04E] = 16'hE000;
    mem[12'h04F] = 16'h0000; mem[12'h050] = 16'hD0F0;
    mem[12'h051] = 16'hB060; mem[12'h060] = 16'hF000;
    mem[12'h005] = 16'h7FFF; mem[12'h006] = 16'h8000;
    mem[12'h007] = 16'h0001; mem[12'h008] = 16'h0000;
    mem[12'h009] = 16'h1234;
    #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_acc", {16'd0, alu_a}, 0);
    chk("rst_b", {16'd0, alu_b}, 0);
    chk("rst_pc", {20'd0, mem_addr}, 0);

    ex(0, 12'h000, 16'h0000); ex(0, 12'h005, 16'h0000);
    ex(0, 12'h001, 16'h7FFF); ex(0, 12'h006, 16'h7FFF);
    ex(0, 12'h002, 16'h8000); ex(0, 12'h006, 16'h8000);
    ex(0, 12'h003, 16'h0000);
    ex(0, 12'h020, 16'h0000); ex(0, 12'h007, 16'h0000);
    ex(0, 12'h021, 16'h0001);
    ex(0, 12'h022, 16'h0000);
    ex(0, 12'h040, 16'h0000); ex(0, 12'h009, 16'h0000);
    ex(0, 12'h041, 16'h1234);
    ex(0, 12'h045, 16'h1234);
    ex(0, 12'h046, 16'h1235); ex(1, 12'h010, 16'h1235);
    ex(0, 12'h047, 16'h1235); ex(0, 12'h008, 16'h1235);
    ex(0, 12'h048, 16'h0000);
    ex(0, 12'h049, 16'h0000); ex(0, 12'h009, 16'h0000);
    ex(0, 12'h04A, 16'hEDCC); ex(0, 12'h009, 16'hEDCC);
    ex(0, 12'h04B, 16'h0004); ex(0, 12'h009, 16'h0004);
    ex(0, 12'h04C, 16'h1234); ex(0, 12'h009, 16'h1234);
    ex(0, 12'h04D, 16'h0000);
    ex(0, 12'h04E, 16'hFFFF);
    ex(0, 12'h04F, 16'hFFFF);
    ex(0, 12'h050, 16'hFFFF);
    ex(0, 12'h051, 16'hFFFF);
    ex(0, 12'h060, 16'hFFFF);
    oq.push_back(16'hFFFF);

    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    k = 0;
    while (!halted && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!halted) $display("FAIL halt_timeout act=%0d req=%0d", k, 400);
    chk("halted", {31'd0, halted}, 1);
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) rd_seen++;
    end
    chk("halt_no_rd", rd_seen, 0);
    chk("halt_acc_frozen", {16'd0, alu_a}, {16'd0, 16'hFFFF});
    chk("sta_wr_cycles", wr_cycles, 4);
    chk("out_pulses", outs, 1);
    chk("run1_q_empty", q.size(), 0);

    @(negedge clk);
    rst_n = 1'b0;
    slow  = 1'b1;
    clr_mem();
    mem[12'h000] = 16'h1006; mem[12'h001] = 16'h3006;
    mem[12'h002] = 16'h1005; mem[12'h003] = 16'h3007;
    mem[12'h005] = 16'h7FFF; mem[12'h006] = 16'h8000;
    mem[12'h007] = 16'h8000;
    ex(0, 12'h000, 16'h0000); ex(0, 12'h006, 16'h0000);
    ex(0, 12'h001, 16'h8000); ex(0, 12'h006, 16'h8000);
    ex(0, 12'h002, 16'h0000); ex(0, 12'h005, 16'h0000);
    ex(0, 12'h003, 16'h7FFF); ex(0, 12'h007, 16'h7FFF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    k = 0;
    while (!(mem_rd && mem_addr == 12'h007) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) $display("FAIL mem_wait_timeout act=%0d req=%0d", k, 200);
    repeat (3) @(negedge clk);
    chk("pre_rst_flags", {30'd0, dut.flags}, 3);
    chk("pre_rst_acc", {16'd0, alu_a}, {16'd0, 16'h7FFF});
    chk("pre_rst_b", {16'd0, alu_b}, {16'd0, 16'h8000});
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pc", {20'd0, mem_addr}, 0);
    chk("abort_acc", {16'd0, alu_a}, 0);
    chk("abort_b", {16'd0, alu_b}, 0);
    chk("abort_flags", {30'd0, dut.flags}, 0);
    chk("abort_rd", {31'd0, mem_rd}, 0);
    chk("abort_halted", {31'd0, halted}, 0);
    chk("abort_pending", q.size(), 1);
    if (q.size() > 0) void'(q.pop_front());
    ex(0, 12'h000, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("run2_q_empty", q.size(), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
